// File: rtl/tlb_miss_ctrl_if.sv
// Bus bundle between the translation-miss controller and its environment:
// requesters, response consumer, flush source, L1 TLB, STLB and page walker.
// master = controller side, slave = environment side.
interface tlb_miss_ctrl_if #(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][63:0] req_va;
    logic [NREQ-1:0][11:0] req_pcid;
    logic [NREQ-1:0]       req_ready;

    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [63:0]           resp_pa;
    logic                  resp_fault;
    logic                  resp_ready;

    logic                  flush_req;
    logic                  flush_done;

    logic [63:0]           tlb_va;
    logic [11:0]           tlb_pcid;
    logic [63:0]           tlb_pa;
    logic                  tlb_insert;
    logic                  tlb_shutdown;
    logic                  tlb_hit;
    logic                  tlb_miss;
    logic [63:0]           tlb_o_addr;

    logic                  stlb_validate;
    logic                  stlb_insert;
    logic                  stlb_shutdown;
    logic                  stlb_hit;
    logic                  stlb_miss;
    logic [63:0]           stlb_o_addr;

    logic                  walk_req;
    logic [63:0]           walk_va;
    logic [11:0]           walk_pcid;
    logic                  walk_ack;
    logic [63:0]           walk_pa;
    logic                  walk_fault;

    modport master (
        input  req_valid, req_va, req_pcid, resp_ready, flush_req,
               tlb_hit, tlb_miss, tlb_o_addr, stlb_hit, stlb_miss, stlb_o_addr,
               walk_ack, walk_pa, walk_fault,
        output req_ready, resp_valid, resp_id, resp_pa, resp_fault, flush_done,
               tlb_va, tlb_pcid, tlb_pa, tlb_insert, tlb_shutdown,
               stlb_validate, stlb_insert, stlb_shutdown,
               walk_req, walk_va, walk_pcid
    );

    modport slave (
        output req_valid, req_va, req_pcid, resp_ready, flush_req,
               tlb_hit, tlb_miss, tlb_o_addr, stlb_hit, stlb_miss, stlb_o_addr,
               walk_ack, walk_pa, walk_fault,
        input  req_ready, resp_valid, resp_id, resp_pa, resp_fault, flush_done,
               tlb_va, tlb_pcid, tlb_pa, tlb_insert, tlb_shutdown,
               stlb_validate, stlb_insert, stlb_shutdown,
               walk_req, walk_va, walk_pcid
    );
endinterface

// File: rtl/tlb_miss_ctrl.sv
// Translation-miss controller: round-robin arbitration over NREQ requesters,
// then L1 lookup -> STLB lookup -> page walk, refilling the lower levels on a
// miss, plus TLB flush sequencing. One request in flight at a time.
// Optional: define TLBC_WALK_TIMEOUT_EN to abort walks after WALK_TIMEOUT cycles.
module tlb_miss_ctrl #(
    parameter int NREQ         = 2,
    parameter int WALK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            shutdown_n,
    tlb_miss_ctrl_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_WALK, S_REFILL, S_RESP, S_FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [63:0]    va_q, va_d;
    logic [11:0]    pcid_q, pcid_d;
    logic [63:0]    pa_q, pa_d;
    logic           fault_q, fault_d;
    logic           from_walk_q, from_walk_d;  // refill must also go to the STLB
    logic           fpend_q, fpend_d;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_oh;
`ifdef TLBC_WALK_TIMEOUT_EN
    logic [15:0]    wcnt_q, wcnt_d;
`endif

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        logic [IDW-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Next-state and datapath capture for the request sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        va_d        = va_q;
        pcid_d      = pcid_q;
        pa_d        = pa_q;
        fault_d     = fault_q;
        from_walk_d = from_walk_q;
        fpend_d     = fpend_q;
        gnt_oh      = '0;
`ifdef TLBC_WALK_TIMEOUT_EN
        wcnt_d      = wcnt_q;
`endif
        // A flush arriving mid-request waits for the request to retire.
        if (bus.flush_req && state_q != S_IDLE && state_q != S_FLUSH)
            fpend_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (fpend_q || bus.flush_req) begin
                    state_d = S_FLUSH;
                end else if (gnt_found) begin
                    gnt_oh[gnt_idx] = 1'b1;
                    id_d        = gnt_idx;
                    va_d        = bus.req_va[gnt_idx];
                    pcid_d      = bus.req_pcid[gnt_idx];
                    fault_d     = 1'b0;
                    from_walk_d = 1'b0;
                    ptr_d       = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d     = S_L1;
                end
            end
            S_L1: begin
                // hit wins if both are reported
                if (bus.tlb_hit) begin
                    pa_d    = bus.tlb_o_addr;
                    state_d = S_RESP;
                end else if (bus.tlb_miss) begin
                    state_d = S_L2;
                end
            end
            S_L2: begin
                if (bus.stlb_hit) begin
                    pa_d    = bus.stlb_o_addr;
                    state_d = S_REFILL;
                end else if (bus.stlb_miss) begin
`ifdef TLBC_WALK_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (bus.walk_ack) begin
                    if (bus.walk_fault) begin
                        pa_d    = '0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        pa_d        = bus.walk_pa;
                        from_walk_d = 1'b1;
                        state_d     = S_REFILL;
                    end
                end
`ifdef TLBC_WALK_TIMEOUT_EN
                // the counter reaches WALK_TIMEOUT at the end of this cycle
                else if (wcnt_q == 16'(WALK_TIMEOUT - 1)) begin
                    pa_d    = '0;
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
`endif
            end
            S_REFILL: state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready)
                    state_d = S_IDLE;
            end
            S_FLUSH: begin
                fpend_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any walk at once.
    always_ff @(posedge clk or negedge shutdown_n) begin
        if (!shutdown_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            va_q        <= '0;
            pcid_q      <= '0;
            pa_q        <= '0;
            fault_q     <= 1'b0;
            from_walk_q <= 1'b0;
            fpend_q     <= 1'b0;
`ifdef TLBC_WALK_TIMEOUT_EN
            wcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            va_q        <= va_d;
            pcid_q      <= pcid_d;
            pa_q        <= pa_d;
            fault_q     <= fault_d;
            from_walk_q <= from_walk_d;
            fpend_q     <= fpend_d;
`ifdef TLBC_WALK_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
`endif
        end
    end

    // Grant is combinational from IDLE; force it low while reset is held.
    assign bus.req_ready     = gnt_oh & {NREQ{shutdown_n}};
    assign bus.resp_valid    = (state_q == S_RESP);
    assign bus.resp_id       = id_q;
    assign bus.resp_pa       = pa_q;
    assign bus.resp_fault    = fault_q;
    assign bus.tlb_va        = va_q;
    assign bus.tlb_pcid      = pcid_q;
    assign bus.tlb_pa        = pa_q;
    assign bus.tlb_insert    = (state_q == S_REFILL);
    assign bus.stlb_insert   = (state_q == S_REFILL) && from_walk_q;
    assign bus.stlb_validate = (state_q == S_L2);
    assign bus.walk_req      = (state_q == S_WALK);
    assign bus.walk_va       = va_q;
    assign bus.walk_pcid     = pcid_q;
    assign bus.tlb_shutdown  = (state_q == S_FLUSH);
    assign bus.stlb_shutdown = (state_q == S_FLUSH);
    assign bus.flush_done    = (state_q == S_FLUSH);
endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// Bench for tlb_miss_ctrl: stubbed TLB/STLB/walker driven by a scenario mode,
// a transaction-level model of expected grants/responses/refills, and a
// per-cycle compare process on the falling edge.
module tb_tlb_miss_ctrl;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic shutdown_n = 1'b0;
    always #5 clk = ~clk;

    tlb_miss_ctrl_if #(.NREQ(NREQ)) bus ();
    tlb_miss_ctrl #(.NREQ(NREQ), .WALK_TIMEOUT(8)) dut (
        .clk(clk), .shutdown_n(shutdown_n), .bus(bus)
    );

    // scenario: 0 L1 hit, 1 STLB hit, 2 walk ok, 3 walk fault, 4 walker never acks
    int          mode    = 0;
    logic [63:0] mode_pa = '0;
    int          wcnt    = 0;

    // environment stubs
    always_comb begin
        bus.tlb_hit     = (mode == 0);
        bus.tlb_miss    = (mode != 0);
        bus.tlb_o_addr  = mode_pa;
        bus.stlb_hit    = bus.stlb_validate && (mode == 1);
        bus.stlb_miss   = bus.stlb_validate && (mode != 1);
        bus.stlb_o_addr = mode_pa;
        bus.walk_ack    = bus.walk_req && (mode == 2 || mode == 3) && (wcnt == 4);
        bus.walk_fault  = bus.walk_ack && (mode == 3);
        bus.walk_pa     = mode_pa;
    end
    always @(posedge clk) wcnt <= bus.walk_req ? wcnt + 1 : 0;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model
    typedef struct {
        int          id;
        int          md;
        logic [63:0] va;
        logic [11:0] pcid;
        logic [63:0] pa;
        logic        fault;
        int          gcyc;
    } txn_t;
    txn_t        q[$];
    int          m_ptr = 0;
    bit          busy = 0, flush_exp = 0, seen_resp = 0;
    int          n_flush = 0, n_ti = 0, n_si = 0;
    int          gnt_log[$];
    logic [63:0] last_pa = '0;
    int          last_id = -1;

    function automatic int lat_exp(input int md);
        case (md)
            0: return 2;   // grant, L1, RESP
            1: return 4;   // + L2, REFILL
            2: return 9;   // + 5 walk cycles, REFILL
            3: return 8;   // + 5 walk cycles, no refill
            default: return 11; // 8 walk cycles then timeout
        endcase
    endfunction

    // Compare process
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        txn_t t;
        int j, gid;
        if (!shutdown_n) begin
            q.delete(); gnt_log.delete();
            m_ptr = 0; busy = 0; flush_exp = 0;
        end else begin
            if (bus.flush_req) flush_exp = 1;
            eg = '0;
            gid = 0;
            if (!busy && !flush_exp)
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (eg == '0 && bus.req_valid[j]) begin eg[j] = 1'b1; gid = j; end
                end
            chk("req_ready", 64'(bus.req_ready), 64'(eg));
            if (eg != '0) begin
                t.id = gid; t.md = mode; t.va = bus.req_va[gid]; t.pcid = bus.req_pcid[gid];
                t.fault = (mode >= 3);
                t.pa = (mode >= 3) ? 64'h0 : mode_pa;
                t.gcyc = cyc;
                q.push_back(t);
                busy = 1; seen_resp = 0; n_ti = 0; n_si = 0;
                m_ptr = (gid + 1) % NREQ;
                gnt_log.push_back(gid);
            end
            if (busy && q.size() > 0) begin
                if (bus.walk_req) begin
                    chk("walk_va", bus.walk_va, q[0].va);
                    chk("walk_pcid", 64'(bus.walk_pcid), 64'(q[0].pcid));
                end
                if (bus.tlb_insert) begin
                    n_ti++;
                    chk("tlb_pa", bus.tlb_pa, q[0].pa);
                    chk("tlb_va", bus.tlb_va, q[0].va);
                    chk("stlb_insert_pair", 64'(bus.stlb_insert), 64'(q[0].md == 2));
                end
                if (bus.stlb_insert) n_si++;
                if (bus.resp_valid) begin
                    if (!seen_resp) begin
                        seen_resp = 1;
                        chk("latency", 64'(cyc - q[0].gcyc), 64'(lat_exp(q[0].md)));
                    end
                    chk("resp_id", 64'(bus.resp_id), 64'(q[0].id));
                    chk("resp_pa", bus.resp_pa, q[0].pa);
                    chk("resp_fault", 64'(bus.resp_fault), 64'(q[0].fault));
                    if (bus.resp_ready) begin
                        chk("n_tlb_insert", 64'(n_ti), 64'(q[0].md == 1 || q[0].md == 2));
                        chk("n_stlb_insert", 64'(n_si), 64'(q[0].md == 2));
                        last_pa = bus.resp_pa; last_id = int'(bus.resp_id);
                        void'(q.pop_front());
                        busy = 0;
                    end
                end
            end else begin
                chk("idle_outputs", 64'({bus.resp_valid, bus.tlb_insert, bus.stlb_insert,
                                         bus.walk_req, bus.stlb_validate}), 64'h0);
            end
            if (bus.flush_done || bus.tlb_shutdown || bus.stlb_shutdown) begin
                chk("flush_trio", 64'({bus.flush_done, bus.tlb_shutdown, bus.stlb_shutdown}), 64'h7);
                chk("flush_expected", 64'(flush_exp), 64'h1);
                chk("flush_while_busy", 64'(busy), 64'h0);
                flush_exp = 0;
                n_flush++;
            end
        end
    end

    task automatic wait_grant(input int id);
        bit got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1;
        end
        if (!got) begin n_chk++; n_fail++; $display("FAIL grant_timeout: requester %0d not granted", id); end
        @(posedge clk); #1;
    endtask

    task automatic wait_resp();
        bit got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (bus.resp_valid && bus.resp_ready) got = 1;
        end
        if (!got) begin n_chk++; n_fail++; $display("FAIL resp_timeout: no response handshake"); end
        @(posedge clk); #1;
    endtask

    task automatic wait_walk();
        bit got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.walk_req) got = 1;
        end
        if (!got) begin n_chk++; n_fail++; $display("FAIL walk_timeout: walk_req never seen"); end
    endtask

    task automatic do_req(input int id, input logic [63:0] va, input logic [11:0] pcid,
                          input int md, input logic [63:0] pa, input int rdly);
        mode = md; mode_pa = pa;
        bus.req_va[id] = va; bus.req_pcid[id] = pcid;
        bus.resp_ready = (rdly == 0);
        bus.req_valid[id] = 1'b1;
        wait_grant(id);
        bus.req_valid[id] = 1'b0;
        if (rdly > 0) begin
            repeat (rdly) @(posedge clk);
            #1 bus.resp_ready = 1'b1;
        end
        wait_resp();
    endtask

    int exp_g[4] = '{0, 1, 0, 1};

    initial begin
        bus.req_valid = '0; bus.req_va = '0; bus.req_pcid = '0;
        bus.resp_ready = 1'b1; bus.flush_req = 1'b0;
        bus.req_valid[0] = 1'b1;   // must not be granted while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_outputs", 64'({bus.resp_valid, bus.resp_fault, bus.walk_req, bus.tlb_insert,
                                bus.stlb_insert, bus.flush_done, bus.stlb_validate}), 64'h0);
        chk("rst_tlb_va", bus.tlb_va, 64'h0);
        bus.req_valid = '0;
        shutdown_n = 1'b1;
        @(posedge clk); #1;

        // L1 hit from requester 1
        do_req(1, 64'hffff_ffff_ffff_fff1, 12'h000, 0, 64'h1000, 0);
        chk("l1hit_pa_lit", last_pa, 64'h1000);
        chk("l1hit_id_lit", 64'(last_id), 64'h1);
        // STLB hit, consumer stalls the response
        do_req(0, 64'h0000_7f00_0000_2abc, 12'h0a5, 1, 64'h2000, 6);
        chk("stlb_pa_lit", last_pa, 64'h2000);
        // full miss, walker acks on its fifth cycle
        do_req(1, 64'h0000_1234_5678_9000, 12'h3ff, 2, 64'h3000, 0);
        chk("walk_pa_lit", last_pa, 64'h3000);
        // walk fault
        do_req(0, 64'h0000_dead_0000_0000, 12'h001, 3, 64'hdead000, 0);
        chk("fault_pa_lit", last_pa, 64'h0);
`ifdef TLBC_WALK_TIMEOUT_EN
        do_req(1, 64'h0000_beef_0000_0000, 12'h002, 4, 64'hbeef000, 0);
        chk("timeout_pa_lit", last_pa, 64'h0);
`endif

        // flush raised mid-walk, requester 1 waiting behind it
        mode = 2; mode_pa = 64'h4000;
        bus.req_va[0] = 64'h0000_0000_4444_0000; bus.req_pcid[0] = 12'h044;
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_walk();
        @(posedge clk); #1 bus.flush_req = 1'b1;
        @(posedge clk); #1 bus.flush_req = 1'b0;
        bus.req_va[1] = 64'h0000_0000_5555_0000; bus.req_pcid[1] = 12'h055;
        bus.req_valid[1] = 1'b1;
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        wait_resp();
        chk("flush_count_lit", 64'(n_flush), 64'h1);

        // reset in the middle of a walk that never completes
        mode = 4; mode_pa = 64'h6000;
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_walk();
        @(posedge clk); #3;
        bus.req_valid = 2'b11;
        shutdown_n = 1'b0;
        #1;
        chk("midwalk_rst_walk_req", 64'(bus.walk_req), 64'h0);
        chk("midwalk_rst_outputs", 64'({bus.req_ready, bus.resp_valid, bus.stlb_validate, bus.resp_fault}), 64'h0);
        chk("midwalk_rst_va", bus.walk_va, 64'h0);
        mode = 0; mode_pa = 64'h5000;
        @(posedge clk); #1 shutdown_n = 1'b1;

        // both requesters held valid: grants alternate from 0
        for (int n = 0; n < 60 && gnt_log.size() < 4; n++) @(negedge clk);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_resp();
        chk("grant_count", 64'(gnt_log.size()), 64'h4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size()) chk("grant_order", 64'(gnt_log[i]), 64'(exp_g[i]));
        chk("queue_empty", 64'(q.size()), 64'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
